// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//
// Purpose: a packed-BCD countdown timer with pause/resume, reload, per-miss
// penalty subtraction and a time-multiplexed 7-segment display driver.
// The count decrements once every TICK_DIV clock cycles while running. A
// rising edge on miss subtracts PENALTY_BCD. Any result at or below zero
// saturates to 0 and the timer expires.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   level: begin or resume counting
//   pause      in   level: freeze counting
//   load       in   level: reload START_BCD and return to idle
//   miss       in   synchronous: a rising edge requests one penalty
//   value_bcd  out  current count, packed BCD, digit 0 in the LSBs
//   running    out  high while counting
//   expired    out  high once the count has reached zero
//   seg        out  {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   an         out  digit anodes, active-low, one-hot-low
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
    parameter int          DIGITS      = 8,
    parameter int          TICK_DIV    = 5000,
    parameter logic [31:0] START_BCD   = 32'h0180_0000,
    parameter logic [31:0] PENALTY_BCD = 32'h0001_0000,
    parameter int          SCAN_SHIFT  = 3,
    parameter int          DP_DIGIT    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  load,
    input  logic                  miss,
    output logic [4*DIGITS-1:0]   value_bcd,
    output logic                  running,
    output logic                  expired,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);
    localparam int W      = 4 * DIGITS;
    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int SCAN_W = (SCAN_SHIFT > 0) ? SCAN_SHIFT : 1;

    localparam logic [W-1:0]      START_VAL = START_BCD[W-1:0];
    localparam logic [W-1:0]      PEN_VAL   = PENALTY_BCD[W-1:0];
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'((1 << SCAN_SHIFT) - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    state_t              r_state;
    logic [W-1:0]        r_value;
    logic [DIV_W-1:0]    r_div;
    logic                r_miss_prev;
    logic                r_running;
    logic                r_expired;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_scan_idx;

    logic                w_tick;
    logic                w_miss_edge;
    logic                w_update;
    logic                w_underflow;
    logic [W-1:0]        w_subtrahend;
    logic [W-1:0]        w_diff;
    logic [DIGITS:0]     w_borrow;
    logic [3:0]          w_digits [DIGITS];
    logic [3:0]          w_cur_digit;

    assign w_tick       = (r_state == S_RUN) && (r_div == DIV_LAST);
    assign w_miss_edge  = miss && !r_miss_prev && (r_state == S_RUN);
    assign w_update     = w_tick || w_miss_edge;
    assign w_subtrahend = w_miss_edge ? PEN_VAL : '0;

    // The tick enters as the borrow into digit 0, so tick + penalty is
    // subtracted in one pass: value - penalty - tick.
    assign w_borrow[0] = w_tick;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_v;
            logic [3:0] w_p;
            assign w_v = r_value[4*gi +: 4];
            assign w_p = w_subtrahend[4*gi +: 4];
            assign w_borrow[gi+1] = ({1'b0, w_v}) < ({1'b0, w_p} + {4'b0000, w_borrow[gi]});
            // On a borrow, adding 10 modulo 16 yields the correct BCD digit.
            assign w_diff[4*gi +: 4] = w_borrow[gi+1]
                ? (w_v + 4'd10 - w_p - {3'b000, w_borrow[gi]})
                : (w_v - w_p - {3'b000, w_borrow[gi]});
            assign w_digits[gi] = r_value[4*gi +: 4];
            assign an[gi] = !(int'(r_scan_idx) == gi);
        end
    endgenerate

    // A borrow out of the top digit means the true result went negative.
    assign w_underflow = w_borrow[DIGITS] || (w_diff == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_value     <= START_VAL;
            r_div       <= '0;
            r_miss_prev <= 1'b0;
            r_running   <= 1'b0;
            r_expired   <= 1'b0;
            r_scan_cnt  <= '0;
            r_scan_idx  <= '0;
        end else begin
            r_miss_prev <= miss;

            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            if (load) begin
                r_state     <= S_IDLE;
                r_value     <= START_VAL;
                r_div       <= '0;
                r_miss_prev <= 1'b0;
                r_running   <= 1'b0;
                r_expired   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_div <= '0;
                        if (start && !pause) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (start && !pause) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // Pause takes the whole cycle: no tick, no penalty.
                        if (pause) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end else if (r_value == '0) begin
                            r_state   <= S_EXPIRED;
                            r_running <= 1'b0;
                            r_expired <= 1'b1;
                            r_div     <= '0;
                        end else begin
                            r_div <= w_tick ? '0 : r_div + 1'b1;
                            if (w_update) begin
                                if (w_underflow) begin
                                    r_value   <= '0;
                                    r_state   <= S_EXPIRED;
                                    r_running <= 1'b0;
                                    r_expired <= 1'b1;
                                    r_div     <= '0;
                                end else begin
                                    r_value <= w_diff;
                                end
                            end
                        end
                    end
                    default: begin
                        r_div <= '0;
                    end
                endcase
            end
        end
    end

    // Display decodes straight from the count register so it never lags.
    assign w_cur_digit = w_digits[r_scan_idx];

    always_comb begin
        seg = 7'b0111111;
        case (w_cur_digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
    end

    assign dp        = !(int'(r_scan_idx) == DP_DIGIT);
    assign value_bcd = r_value;
    assign running   = r_running;
    assign expired   = r_expired;

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter: DIGITS, 8, number of BCD digits counted and displayed (legal 2..8).
REQ-002 Parameter: TICK_DIV, 5000, clock cycles per count tick (legal >= 2).
REQ-003 Parameter: START_BCD, 32'h0180_0000, packed BCD reload value (low 4*DIGITS bits used).
REQ-004 Parameter: PENALTY_BCD, 32'h0001_0000, packed BCD amount subtracted per miss.
REQ-005 Parameter: SCAN_SHIFT, 3, each digit is driven for 2^SCAN_SHIFT cycles.
REQ-006 Parameter: DP_DIGIT, 4, digit index whose decimal point is lit.
REQ-007 Reset and clock: reset, asynchronous, active-high; clock clock.
REQ-008 Port: clock  in  1  system clock.
REQ-009 Port: reset  in  1  async active-high reset.
REQ-010 Port: start  in  1  level; begin or resume counting.
REQ-011 Port: pause  in  1  level; freeze counting.
REQ-012 Port: load  in  1  level; reload START_BCD and return to IDLE.
REQ-013 Port: miss  in  1  synchronous; rising edge requests one penalty.
REQ-014 Port: value_bcd  out  4*DIGITS  current count, packed BCD, digit 0 in LSBs.
REQ-015 Port: running  out  1  high in RUN.
REQ-016 Port: expired  out  1  high in EXPIRED.
REQ-017 Port: seg  out  7  {g,f,e,d,c,b,a}, active-low.
REQ-018 Port: dp  out  1  decimal point, active-low.
REQ-019 Port: an  out  DIGITS  digit anodes, active-low, one-hot-low.

Function
REQ-020 States IDLE, RUN, PAUSE, EXPIRED; priority per cycle: load > pause > start.
REQ-021 Any state, load=1 -> IDLE, value=START_BCD, divider=0, miss edge detector cleared.
REQ-022 IDLE or PAUSE, start=1, pause=0 -> RUN; RUN, pause=1 -> PAUSE; EXPIRED left only by load or reset.
REQ-023 Divider counts 0..TICK_DIV-1 only in RUN; tick asserted in the cycle divider==TICK_DIV-1, then wraps to 0; held in PAUSE, cleared in IDLE/EXPIRED.
REQ-024 Tick in RUN: value decrements by 1 in BCD with borrow ripple (e.g. 0100 -> 0099), updated at the edge ending the tick cycle.
REQ-025 Miss edge (miss=1, previous-cycle miss=0) in RUN: value -= PENALTY_BCD at next edge; edges outside RUN discarded; miss held high yields one penalty.
REQ-026 Tick and miss edge in same cycle: value -= PENALTY_BCD + 1 in one update.
REQ-027 Any subtraction whose true result <= 0 saturates value to 0 and enters EXPIRED at the same edge; no wrap-around.
REQ-028 RUN with value already 0 (START_BCD=0) -> EXPIRED at next edge.
REQ-029 Subtraction performed digit-wise in BCD; no binary divide/modulo for display digits.
REQ-030 Scan: digit index advances every 2^SCAN_SHIFT cycles, 0..DIGITS-1 then wraps to 0; scan runs in all states.
REQ-031 an bit [index]=0, all others 1; seg = decode of value_bcd digit [index]; dp=0 iff index==DP_DIGIT, else 1.
REQ-032 Decode (active-low, gfedcba): 0=1000000,1=1111001,2=0100100,3=0110000,4=0011001,5=0010010,6=0000010,7=1111000,8=0000000,9=0010000; non-BCD nibble = 0111111 (dash).
REQ-033 Display shows current value_bcd with no lag behind the count register.
REQ-034 running and expired are registered state decodes; never both high.

Reset
REQ-035 On reset: state IDLE, value_bcd=START_BCD, divider=0, scan index=0, scan counter=0, miss edge detector=0, running=0, expired=0.
REQ-036 During reset: an=all ones except bit 0 low, seg=decode of START_BCD digit 0, dp=1 (unless DP_DIGIT=0, then 0).
REQ-037 Reset asserted mid-RUN or mid-EXPIRED takes effect immediately, independent of clock.

Verification (DIGITS=4, TICK_DIV=4, START_BCD=0012, PENALTY_BCD=0005, SCAN_SHIFT=2, DP_DIGIT=1)
REQ-038 Reset, start pulse -> running=1; value 0011 after 4 cycles; 0000 after 48 RUN cycles with expired=1, running=0, value stays 0000.
REQ-039 Force START_BCD=0100, run one tick -> value 0099; further start/pause in EXPIRED ignored.
REQ-040 At value 0012 in RUN, miss high 3 cycles -> value 0007 once; miss edge at 0003 -> 0000, expired=1.
REQ-041 Tick and miss edge same cycle at 0012 -> 0006; miss edge in PAUSE -> value unchanged.
REQ-042 Pause mid-count freezes value and divider; start resumes, next tick after remaining divider cycles; load in EXPIRED -> IDLE, 0012, expired=0.
REQ-043 Scan check: an sequence 1110,1101,1011,0111 each 4 cycles, repeating; dp=0 only while an=1101; nibble 0xA forced -> seg=0111111.
